// File: rtl/memory_stage2_pkg.sv
// Shared types and constants for the memory stage 2 slice: cycle widths,
// opcodes, access timeout and the alignment rule.
package memory_stage2_pkg;

  typedef logic [1:0] t_cycle_width;

  localparam t_cycle_width BYTE = 2'd0;
  localparam t_cycle_width WORD = 2'd1;
  localparam t_cycle_width LONG = 2'd2;

  localparam logic [4:0] OPCODE_NOP   = 5'h00;
  localparam logic [4:0] OPCODE_LOAD  = 5'h08;
  localparam logic [4:0] OPCODE_STORE = 5'h09;

  localparam logic [31:0] NOP_INSTRUCTION = {OPCODE_NOP, 27'h0};

  localparam logic [7:0] ACCESS_TIMEOUT = 8'd255;

  // Width code 3 never aligns, so it is rejected like a misaligned access.
  function automatic logic is_aligned(input t_cycle_width width, input logic [1:0] offset);
    case (width)
      BYTE:    is_aligned = 1'b1;
      WORD:    is_aligned = (offset[0] == 1'b0);
      LONG:    is_aligned = (offset == 2'b00);
      default: is_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage2_if.sv
// Longword data bus between memory stage 2 (master) and the memory system.
interface memory_stage2_if;

  logic [29:0] bus_address;
  logic [3:0]  bus_data_strobes;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_data_out;
  logic [31:0] bus_data_in;
  logic        bus_ack;

  modport master (
    output bus_address, bus_data_strobes, bus_read, bus_write, bus_data_out,
    input  bus_data_in, bus_ack
  );

  modport slave (
    input  bus_address, bus_data_strobes, bus_read, bus_write, bus_data_out,
    output bus_data_in, bus_ack
  );

endinterface

// File: rtl/memory_stage2_buslanes.sv
// Big-endian byte-lane mapping: strobes and store replication from width and
// address offset, plus zero-extended load extraction from the bus word.
module memory_stage2_buslanes
  import memory_stage2_pkg::*;
(
  input  t_cycle_width width,
  input  logic [1:0]   offset,
  input  logic [31:0]  store_data,
  input  logic [31:0]  load_data,
  output logic [3:0]   strobes,
  output logic [31:0]  store_lanes,
  output logic [31:0]  load_value
);

  always_comb begin
    strobes     = 4'b0000;
    store_lanes = 32'h0;
    load_value  = 32'h0;
    case (width)
      BYTE: begin
        strobes     = 4'b1000 >> offset;
        store_lanes = {4{store_data[7:0]}};
        case (offset)
          2'd0:    load_value = {24'h0, load_data[31:24]};
          2'd1:    load_value = {24'h0, load_data[23:16]};
          2'd2:    load_value = {24'h0, load_data[15:8]};
          default: load_value = {24'h0, load_data[7:0]};
        endcase
      end
      WORD: begin
        strobes     = offset[1] ? 4'b0011 : 4'b1100;
        store_lanes = {2{store_data[15:0]}};
        load_value  = offset[1] ? {16'h0, load_data[15:0]} : {16'h0, load_data[31:16]};
      end
      LONG: begin
        strobes     = 4'b1111;
        store_lanes = store_data;
        load_value  = load_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_stage2.sv
// Memory stage 2: issues load/store bus cycles, stalls upstream while a cycle
// is outstanding, and writes load results back to the register file.
module memory_stage2
  import memory_stage2_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         inbound_instruction,
  input  logic                memory_access_cycle,
  input  logic                memory_read,
  input  logic                memory_write,
  input  t_cycle_width        memory_cycle_width,
  input  logic [3:0]          reg_data_index,
  input  logic [31:0]         reg_address_data,
  input  logic [31:0]         reg_data_data,
  memory_stage2_if.master     bus,
  output logic                stall,
  output logic                bus_error,
  output logic                alignment_error,
  output logic                reg_write,
  output logic [3:0]          reg_write_index,
  output logic [31:0]         reg_write_data,
  output logic [31:0]         outbound_instruction
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]         state_p1;
  logic signed [31:0] offset_sext_p0;
  logic [31:0]        ea_p0;
  logic               aligned_p0;

  logic [31:0]        instr_p1;
  logic [3:0]         index_p1;
  t_cycle_width       width_p1;
  logic [1:0]         offset_p1;
  logic               load_p1;
  logic [7:0]         wait_cnt_p1;

  t_cycle_width       lane_width;
  logic [1:0]         lane_offset;
  logic [3:0]         lane_strobes;
  logic [31:0]        lane_store;
  logic [31:0]        lane_load;

  // Stage p0: effective address and alignment of the incoming request
  assign offset_sext_p0 = {{16{inbound_instruction[15]}}, inbound_instruction[15:0]};
  assign ea_p0          = reg_address_data + $unsigned(offset_sext_p0);
  assign aligned_p0     = is_aligned(memory_cycle_width, ea_p0[1:0]);

  // Lanes follow the live request in IDLE and the captured request in ACCESS.
  assign lane_width  = (state_p1 == ACCESS) ? width_p1  : memory_cycle_width;
  assign lane_offset = (state_p1 == ACCESS) ? offset_p1 : ea_p0[1:0];

  memory_stage2_buslanes u_buslanes (
    .width       (lane_width),
    .offset      (lane_offset),
    .store_data  (reg_data_data),
    .load_data   (bus.bus_data_in),
    .strobes     (lane_strobes),
    .store_lanes (lane_store),
    .load_value  (lane_load)
  );

  assign stall = (state_p1 == ACCESS);

  // Stage p1: bus cycle state, captured request and writeback registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_p1              <= IDLE;
      bus.bus_address       <= 30'h0;
      bus.bus_data_strobes  <= 4'b0000;
      bus.bus_read          <= 1'b0;
      bus.bus_write         <= 1'b0;
      bus.bus_data_out      <= 32'h0;
      bus_error             <= 1'b0;
      alignment_error       <= 1'b0;
      reg_write             <= 1'b0;
      reg_write_index       <= 4'h0;
      reg_write_data        <= 32'h0;
      outbound_instruction  <= NOP_INSTRUCTION;
      instr_p1              <= 32'h0;
      index_p1              <= 4'h0;
      width_p1              <= BYTE;
      offset_p1             <= 2'b00;
      load_p1               <= 1'b0;
      wait_cnt_p1           <= 8'h0;
    end else begin
      reg_write       <= 1'b0;
      bus_error       <= 1'b0;
      alignment_error <= 1'b0;
      case (state_p1)
        IDLE: begin
          if (memory_access_cycle) begin
            outbound_instruction <= NOP_INSTRUCTION;
            if (aligned_p0) begin
              state_p1             <= ACCESS;
              bus.bus_address      <= ea_p0[31:2];
              bus.bus_data_strobes <= lane_strobes;
              bus.bus_data_out     <= lane_store;
              bus.bus_read         <= memory_read;
              bus.bus_write        <= memory_write;
              instr_p1             <= inbound_instruction;
              index_p1             <= reg_data_index;
              width_p1             <= memory_cycle_width;
              offset_p1            <= ea_p0[1:0];
              load_p1              <= memory_read;
              wait_cnt_p1          <= 8'h0;
            end else begin
              alignment_error <= 1'b1;
            end
          end else begin
            outbound_instruction <= inbound_instruction;
          end
        end
        default: begin
          if (bus.bus_ack) begin
            state_p1             <= IDLE;
            bus.bus_data_strobes <= 4'b0000;
            bus.bus_read         <= 1'b0;
            bus.bus_write        <= 1'b0;
            outbound_instruction <= instr_p1;
            if (load_p1) begin
              reg_write       <= 1'b1;
              reg_write_index <= index_p1;
              reg_write_data  <= lane_load;
            end
          end else if (wait_cnt_p1 == ACCESS_TIMEOUT - 8'd1) begin
            // The 255th unacknowledged cycle ends the access.
            state_p1             <= IDLE;
            bus.bus_data_strobes <= 4'b0000;
            bus.bus_read         <= 1'b0;
            bus.bus_write        <= 1'b0;
            bus_error            <= 1'b1;
            outbound_instruction <= NOP_INSTRUCTION;
            wait_cnt_p1          <= ACCESS_TIMEOUT;
          end else begin
            wait_cnt_p1          <= wait_cnt_p1 + 8'd1;
            outbound_instruction <= NOP_INSTRUCTION;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage2.sv
// Directed bench for memory_stage2: loads, stores, alignment, timeout, reset.
module tb_memory_stage2;
  import memory_stage2_pkg::*;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [31:0]  inbound_instruction = 32'h0;
  logic         memory_access_cycle = 1'b0;
  logic         memory_read = 1'b0;
  logic         memory_write = 1'b0;
  t_cycle_width memory_cycle_width = BYTE;
  logic [3:0]   reg_data_index = 4'h0;
  logic [31:0]  reg_address_data = 32'h0;
  logic [31:0]  reg_data_data = 32'h0;
  logic         stall;
  logic         bus_error;
  logic         alignment_error;
  logic         reg_write;
  logic [3:0]   reg_write_index;
  logic [31:0]  reg_write_data;
  logic [31:0]  outbound_instruction;

  int vectors = 0;
  int miscompares = 0;

  memory_stage2_if bus_if ();

  memory_stage2 dut (
    .clock                (clock),
    .reset                (reset),
    .inbound_instruction  (inbound_instruction),
    .memory_access_cycle  (memory_access_cycle),
    .memory_read          (memory_read),
    .memory_write         (memory_write),
    .memory_cycle_width   (memory_cycle_width),
    .reg_data_index       (reg_data_index),
    .reg_address_data     (reg_address_data),
    .reg_data_data        (reg_data_data),
    .bus                  (bus_if.master),
    .stall                (stall),
    .bus_error            (bus_error),
    .alignment_error      (alignment_error),
    .reg_write            (reg_write),
    .reg_write_index      (reg_write_index),
    .reg_write_data       (reg_write_data),
    .outbound_instruction (outbound_instruction)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic request(input logic [31:0] instr, input logic [31:0] base,
                         input t_cycle_width w, input logic rd, input logic wr,
                         input logic [3:0] idx, input logic [31:0] wdata);
    inbound_instruction = instr;
    reg_address_data    = base;
    memory_cycle_width  = w;
    memory_read         = rd;
    memory_write        = wr;
    reg_data_index      = idx;
    reg_data_data       = wdata;
    memory_access_cycle = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus_if.bus_ack = 1'b0;
    bus_if.bus_data_in = 32'h0;
    #3;
    vectors++;
    if ({stall, bus_if.bus_read, bus_if.bus_write, bus_if.bus_data_strobes, reg_write, bus_error, alignment_error} !== 10'h0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 0", {stall, bus_if.bus_read, bus_if.bus_write, bus_if.bus_data_strobes, reg_write, bus_error, alignment_error});
    end
    vectors++;
    if ({bus_if.bus_address, bus_if.bus_data_out, reg_write_data, reg_write_index} !== 98'h0) begin
      miscompares++;
      $display("FAIL reset_data: addr %h out %h wdata %h idx %h want 0", bus_if.bus_address, bus_if.bus_data_out, reg_write_data, reg_write_index);
    end
    vectors++;
    if (outbound_instruction !== NOP_INSTRUCTION) begin
      miscompares++;
      $display("FAIL reset_outbound: got %h want %h", outbound_instruction, NOP_INSTRUCTION);
    end
    @(negedge clock);
    reset = 1'b1;
    step();
  endtask

  task automatic test_passthrough();
    inbound_instruction = 32'h1234_5678;
    memory_access_cycle = 1'b0;
    bus_if.bus_ack = 1'b1;
    step();
    vectors++;
    if (outbound_instruction !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL pass_outbound: got %h want 12345678", outbound_instruction);
    end
    vectors++;
    if ({stall, bus_if.bus_read, bus_if.bus_write, reg_write} !== 4'b0000) begin
      miscompares++;
      $display("FAIL pass_idle_ack: got %b want 0000", {stall, bus_if.bus_read, bus_if.bus_write, reg_write});
    end
    bus_if.bus_ack = 1'b0;
  endtask

  task automatic test_long_load();
    int stalls = 0;
    request(32'h4000_FF00, 32'h0000_0200, LONG, 1'b1, 1'b0, 4'd5, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      step();
      if (stall) stalls++;
      if (c == 1) begin
        vectors++;
        if (bus_if.bus_address !== 30'h40 || bus_if.bus_data_strobes !== 4'b1111 || bus_if.bus_read !== 1'b1) begin
          miscompares++;
          $display("FAIL long_issue: addr %h strb %b rd %b want 40 1111 1", bus_if.bus_address, bus_if.bus_data_strobes, bus_if.bus_read);
        end
        vectors++;
        if (outbound_instruction !== NOP_INSTRUCTION) begin
          miscompares++;
          $display("FAIL long_nop: got %h want %h", outbound_instruction, NOP_INSTRUCTION);
        end
      end
      if (c == 3) begin
        bus_if.bus_ack = 1'b1;
        bus_if.bus_data_in = 32'hDEAD_BEEF;
        memory_access_cycle = 1'b0;
      end
    end
    step();
    bus_if.bus_ack = 1'b0;
    vectors++;
    if (stalls != 3 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL long_stall: stall cycles %0d now %b want 3 0", stalls, stall);
    end
    vectors++;
    if (reg_write !== 1'b1 || reg_write_data !== 32'hDEAD_BEEF || reg_write_index !== 4'd5) begin
      miscompares++;
      $display("FAIL long_wb: we %b data %h idx %h want 1 deadbeef 5", reg_write, reg_write_data, reg_write_index);
    end
    vectors++;
    if (outbound_instruction !== 32'h4000_FF00 || bus_if.bus_read !== 1'b0 || bus_if.bus_data_strobes !== 4'b0000) begin
      miscompares++;
      $display("FAIL long_done: out %h rd %b strb %b want 4000ff00 0 0000", outbound_instruction, bus_if.bus_read, bus_if.bus_data_strobes);
    end
    step();
    vectors++;
    if (reg_write !== 1'b0) begin
      miscompares++;
      $display("FAIL long_pulse: reg_write %b want 0", reg_write);
    end
  endtask

  task automatic test_byte_store();
    request(32'h4800_0003, 32'h0000_0200, BYTE, 1'b0, 1'b1, 4'd2, 32'h1234_5678);
    step();
    vectors++;
    if (bus_if.bus_data_strobes !== 4'b0001 || bus_if.bus_data_out !== 32'h7878_7878 || bus_if.bus_address !== 30'h80) begin
      miscompares++;
      $display("FAIL byte_issue: strb %b out %h addr %h want 0001 78787878 80", bus_if.bus_data_strobes, bus_if.bus_data_out, bus_if.bus_address);
    end
    vectors++;
    if (bus_if.bus_write !== 1'b1 || bus_if.bus_read !== 1'b0) begin
      miscompares++;
      $display("FAIL byte_rw: wr %b rd %b want 1 0", bus_if.bus_write, bus_if.bus_read);
    end
    bus_if.bus_ack = 1'b1;
    memory_access_cycle = 1'b0;
    step();
    bus_if.bus_ack = 1'b0;
    vectors++;
    if (reg_write !== 1'b0 || bus_if.bus_write !== 1'b0 || outbound_instruction !== 32'h4800_0003) begin
      miscompares++;
      $display("FAIL byte_done: we %b wr %b out %h want 0 0 48000003", reg_write, bus_if.bus_write, outbound_instruction);
    end
  endtask

  task automatic test_word_load();
    request(32'h4000_0002, 32'h0000_0100, WORD, 1'b1, 1'b0, 4'd9, 32'h0);
    step();
    vectors++;
    if (bus_if.bus_data_strobes !== 4'b0011) begin
      miscompares++;
      $display("FAIL word_strobes: got %b want 0011", bus_if.bus_data_strobes);
    end
    bus_if.bus_ack = 1'b1;
    bus_if.bus_data_in = 32'hAAAA_8001;
    memory_access_cycle = 1'b0;
    step();
    bus_if.bus_ack = 1'b0;
    vectors++;
    if (reg_write !== 1'b1 || reg_write_data !== 32'h0000_8001 || reg_write_index !== 4'd9) begin
      miscompares++;
      $display("FAIL word_wb: we %b data %h idx %h want 1 00008001 9", reg_write, reg_write_data, reg_write_index);
    end
  endtask

  task automatic test_misaligned();
    request(32'h4000_0002, 32'h0000_0100, LONG, 1'b1, 1'b0, 4'd1, 32'h0);
    step();
    vectors++;
    if (alignment_error !== 1'b1 || bus_if.bus_read !== 1'b0 || stall !== 1'b0 || outbound_instruction !== NOP_INSTRUCTION) begin
      miscompares++;
      $display("FAIL misalign_long: aerr %b rd %b stall %b out %h want 1 0 0 %h", alignment_error, bus_if.bus_read, stall, outbound_instruction, NOP_INSTRUCTION);
    end
    request(32'h4000_0000, 32'h0000_0100, 2'd3, 1'b1, 1'b0, 4'd1, 32'h0);
    step();
    vectors++;
    if (alignment_error !== 1'b1 || bus_if.bus_read !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_w3: aerr %b rd %b want 1 0", alignment_error, bus_if.bus_read);
    end
    memory_access_cycle = 1'b0;
    step();
    vectors++;
    if (alignment_error !== 1'b0 || outbound_instruction !== 32'h4000_0000) begin
      miscompares++;
      $display("FAIL misalign_pulse: aerr %b out %h want 0 40000000", alignment_error, outbound_instruction);
    end
  endtask

  task automatic test_timeout();
    int stalls = 0;
    request(32'h4000_0000, 32'h0000_0100, LONG, 1'b1, 1'b0, 4'd3, 32'h0);
    step();
    memory_access_cycle = 1'b0;
    while (stall && stalls < 300) begin
      stalls++;
      step();
    end
    vectors++;
    if (stalls != 255) begin
      miscompares++;
      $display("FAIL timeout_len: access cycles %0d want 255", stalls);
    end
    vectors++;
    if (bus_error !== 1'b1 || reg_write !== 1'b0 || bus_if.bus_read !== 1'b0 || outbound_instruction !== NOP_INSTRUCTION) begin
      miscompares++;
      $display("FAIL timeout_abort: berr %b we %b rd %b out %h want 1 0 0 %h", bus_error, reg_write, bus_if.bus_read, outbound_instruction, NOP_INSTRUCTION);
    end
    step();
    vectors++;
    if (bus_error !== 1'b0 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_pulse: berr %b stall %b want 0 0", bus_error, stall);
    end
  endtask

  task automatic test_reset_mid_access();
    request(32'h4000_0000, 32'h0000_0100, LONG, 1'b1, 1'b0, 4'd7, 32'h0);
    step();
    memory_access_cycle = 1'b0;
    step();
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({stall, bus_if.bus_read, bus_if.bus_data_strobes} !== 6'h0 || bus_if.bus_address !== 30'h0 || outbound_instruction !== NOP_INSTRUCTION) begin
      miscompares++;
      $display("FAIL midreset_now: stall %b rd %b strb %b addr %h out %h want 0 0 0000 0 %h", stall, bus_if.bus_read, bus_if.bus_data_strobes, bus_if.bus_address, outbound_instruction, NOP_INSTRUCTION);
    end
    bus_if.bus_ack = 1'b1;
    bus_if.bus_data_in = 32'h5555_5555;
    #1;
    reset = 1'b1;
    step();
    vectors++;
    if (reg_write !== 1'b0 || bus_error !== 1'b0 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_after: we %b berr %b stall %b want 0 0 0", reg_write, bus_error, stall);
    end
    bus_if.bus_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_long_load();
    test_byte_store();
    test_word_load();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/memory_stage2.md
MEMORY_STAGE2 -- requirements
Module: memorystage2

Interface
REQ-001 SHALL have ports: clock  input  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset  input  1  asynchronous, active-low.
REQ-003 SHALL have ports: inbound_instruction  input  32  instruction from memorystage1; opcode in [31:27], signed offset in [15:0].
REQ-004 SHALL have ports: memory_access_cycle, memory_read, memory_write  input  1 each  access request flags from memorystage1.
REQ-005 SHALL have ports: memory_cycle_width  input  t_cycle_width  BYTE=0, WORD=1, LONG=2; 3 is illegal.
REQ-006 SHALL have ports: reg_data_index  input  4  load destination register index.
REQ-007 SHALL have ports: reg_address_data, reg_data_data  input  32 each  register file values for the address register and the data register.
REQ-008 SHALL have ports: bus_address  output  30  longword address [31:2].
REQ-009 SHALL have ports: bus_data_strobes  output  4  byte lanes; bit 3 = bits [31:24].
REQ-010 SHALL have ports: bus_read, bus_write  output  1 each; bus_data_out  output  32; bus_data_in  input  32; bus_ack  input  1.
REQ-011 SHALL have ports: stall  output  1  freezes memorystage1 and fetch.
REQ-012 SHALL have ports: bus_error, alignment_error  output  1 each  one-cycle error pulses.
REQ-013 SHALL have ports: reg_write  output  1; reg_write_index  output  4; reg_write_data  output  32  register writeback.
REQ-014 SHALL have ports: outbound_instruction  output  32  instruction to the next stage.

Function
REQ-015 SHALL compute the effective address as reg_address_data plus sign-extended inbound_instruction[15:0], modulo 2^32.
REQ-016 SHALL use a state machine with states IDLE and ACCESS.
REQ-017 SHALL, in IDLE with memory_access_cycle=0, register inbound_instruction to outbound_instruction with 1-cycle latency and drive no bus activity.
REQ-018 SHALL, in IDLE with memory_access_cycle=1 and a legal aligned access, enter ACCESS at the next edge with the following registered: bus_address, strobes, bus_data_out, bus_read=memory_read, bus_write=memory_write.
REQ-019 SHALL define alignment: BYTE any address; WORD requires ea[0]=0; LONG requires ea[1:0]=0; width 3 is always misaligned.
REQ-020 SHALL, on a misaligned request, start no bus cycle, pulse alignment_error for 1 cycle, and pass OPCODE_NOP on outbound_instruction.
REQ-021 SHALL use big-endian lanes: BYTE at offset n drives strobe bit 3-n; WORD at offset 0 drives strobes 1100, at offset 2 drives 0011; LONG drives 1111.
REQ-022 SHALL, for a store, replicate reg_data_data low byte or low word onto all matching lanes of bus_data_out.
REQ-023 SHALL assert stall combinationally whenever the state is ACCESS; upstream holds its outputs while stall=1.
REQ-024 SHALL drive outbound_instruction as OPCODE_NOP while in ACCESS.
REQ-025 SHALL maintain an 8-bit wait counter that clears on entry to ACCESS and increments each ACCESS cycle without bus_ack.
REQ-026 SHALL, when bus_ack is sampled high in ACCESS, at that edge: deassert bus_read/bus_write/strobes, return to IDLE, and set outbound_instruction to the memory instruction.
REQ-027 SHALL, on load completion, capture the selected lane zero-extended to 32 bits and pulse reg_write for 1 cycle with reg_write_index = captured reg_data_index.
REQ-028 SHALL, on store completion, leave reg_write low.
REQ-029 SHALL, if the wait counter reaches 255 without bus_ack, abort the cycle: pulse bus_error, perform no writeback, pass OPCODE_NOP, and return to IDLE.
REQ-030 SHALL, if bus_ack and timeout coincide, treat the access as a successful completion.
REQ-031 SHALL ignore bus_ack while in IDLE.

Reset
REQ-032 SHALL, while reset=0, asynchronously force: state IDLE; bus_read, bus_write, strobes, stall, reg_write, bus_error, alignment_error to 0; bus_address, bus_data_out, reg_write_data, reg_write_index, wait counter to 0; outbound_instruction to {OPCODE_NOP, 27'h0}.
REQ-033 SHALL, on reset mid-ACCESS, abandon the cycle with no writeback and no error pulse.

Structure
REQ-034 SHALL take t_cycle_width and its BYTE/WORD/LONG constants from registers.vh, and opcode constants from opcodes.vh.
REQ-035 SHALL add the ACCESS timeout limit (255) as a constant in the shared package.
REQ-036 SHALL be implemented as a natural sub-module, buslanes, that is combinational and maps width and offset to strobes, store data replication and load extraction.

Verification
REQ-037 SHALL cover: LONG load, ea=0x100, bus_ack on the 3rd ACCESS cycle, bus_data_in=0xDEADBEEF -> stall high for 3 cycles, strobes 1111, reg_write pulse with data 0xDEADBEEF.
REQ-038 SHALL cover: BYTE store, ea=0x203, reg_data_data=0x12345678 -> strobes 0001, bus_data_out=0x78787878, no reg_write.
REQ-039 SHALL cover: WORD load, ea=0x102, bus_data_in=0xAAAA8001 -> reg_write_data 0x00008001.
REQ-040 SHALL cover: LONG access, ea=0x102 -> alignment_error pulse, no bus_read, outbound NOP.
REQ-041 SHALL cover: load with bus_ack never asserted -> bus_error after 255 ACCESS cycles, no reg_write, IDLE next cycle.
REQ-042 SHALL cover: reset=0 asserted during ACCESS -> all outputs at reset values immediately, no writeback after release.
